// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one operand bit per clock through a 1-bit full adder.
// Define SERIAL_SUB_EN to add the sub port and A-B (two's complement) support.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             sub_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             sub_in;
  logic             b_bit;
  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

`ifdef SERIAL_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert the B bit, carry flop starts at 1.
  assign b_bit      = b_reg[0] ^ sub_reg;
  assign sum_bit    = a_reg[0] ^ b_bit ^ carry_reg;
  assign carry_next = (a_reg[0] & b_bit) | (carry_reg & (a_reg[0] ^ b_bit));
  assign res_next   = {sum_bit, res_reg[WIDTH-1:1]};
  assign last_bit   = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      cout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg <= SHIFT;
            a_reg     <= a;
            b_reg     <= b;
            sub_reg   <= sub_in;
            carry_reg <= sub_in;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
          end
        end
        SHIFT: begin
          res_reg   <= res_next;
          a_reg     <= {1'b0, a_reg[WIDTH-1:1]};
          b_reg     <= {1'b0, b_reg[WIDTH-1:1]};
          carry_reg <= carry_next;
          cnt_reg   <= cnt_reg + CW'(1);
          if (last_bit) begin
            state_reg <= DONE;
            sum_reg   <= res_next;
            // Borrow out is the complement of the final carry when subtracting.
            cout_reg  <= carry_next ^ sub_reg;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
